branch_issue_queue: RTL and testbench

- In-order issue queue for branch/jump instructions.
- Sits between dispatch and the branch execution unit (BEU).
- Holds up to DEPTH branches and captures operand values from the writeback bus as producers complete.
- Issues the head entry to the BEU once both its source operands are ready; `flush_i` empties the queue.

---
 rtl/branch_issue_queue_pkg.sv | 26 ++
 rtl/branch_iq_entry.sv | 64 ++++++
 rtl/branch_issue_queue.sv | 125 ++++++++++++
 tb/tb_branch_issue_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_issue_queue_pkg.sv
// Shared branch IQ definitions: scoreboard id width, func codes, entry layout.
// Optional feature macro used by the queue: BRANCH_IQ_FWD_EN.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 6
`endif

package branch_issue_queue_pkg;
    localparam int SID_W = `SCOREBOARD_SIZE_WIDTH;

    localparam logic [3:0] FUNC_JAL    = 4'b0111;
    localparam logic [3:0] FUNC_JALR   = 4'b0101;
    localparam logic [3:0] FUNC_BRANCH = 4'b0100;

    typedef struct packed {
        logic [63:0]      pc;
        logic [31:0]      inst;
        logic [SID_W-1:0] sid;
        logic [3:0]       func;
        logic             rs1_ready;
        logic [SID_W-1:0] rs1_sid;
        logic [63:0]      rs1_value;
        logic             rs2_ready;
        logic [SID_W-1:0] rs2_sid;
        logic [63:0]      rs2_value;
    } biq_entry_t;
endpackage

// File: rtl/branch_iq_entry.sv
// One branch IQ slot: storage plus per-operand writeback compare and capture.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 6
`endif

module branch_iq_entry
    import branch_issue_queue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr,
    input  logic             i_clr,
    input  biq_entry_t       i_data,
    input  logic             i_wb_valid,
    input  logic [SID_W-1:0] i_wb_sid,
    input  logic [63:0]      i_wb_value,
    output logic             o_valid,
    output biq_entry_t       o_data
);
    logic       r_valid;
    biq_entry_t r_data;

    // A writeback in the dispatch cycle is captured into the incoming operand.
    logic w_wr_hit1, w_wr_hit2, w_wk1, w_wk2;
    assign w_wr_hit1 = i_wb_valid & ~i_data.rs1_ready & (i_data.rs1_sid == i_wb_sid);
    assign w_wr_hit2 = i_wb_valid & ~i_data.rs2_ready & (i_data.rs2_sid == i_wb_sid);
    assign w_wk1     = r_valid & i_wb_valid & ~r_data.rs1_ready & (r_data.rs1_sid == i_wb_sid);
    assign w_wk2     = r_valid & i_wb_valid & ~r_data.rs2_ready & (r_data.rs2_sid == i_wb_sid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            if (w_wr_hit1) begin
                r_data.rs1_ready <= 1'b1;
                r_data.rs1_value <= i_wb_value;
            end
            if (w_wr_hit2) begin
                r_data.rs2_ready <= 1'b1;
                r_data.rs2_value <= i_wb_value;
            end
        end else begin
            if (i_clr)
                r_valid <= 1'b0;
            if (w_wk1) begin
                r_data.rs1_ready <= 1'b1;
                r_data.rs1_value <= i_wb_value;
            end
            if (w_wk2) begin
                r_data.rs2_ready <= 1'b1;
                r_data.rs2_value <= i_wb_value;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue between dispatch and the BEU.
// BRANCH_IQ_FWD_EN: head operands may wake from the same-cycle writeback.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 6
`endif

module branch_issue_queue
    import branch_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [63:0]      disp_pc_i,
    input  logic [31:0]      disp_inst_i,
    input  logic [SID_W-1:0] disp_sid_i,
    input  logic [3:0]       disp_func_code_i,
    input  logic             disp_rs1_ready_i,
    input  logic             disp_rs2_ready_i,
    input  logic [SID_W-1:0] disp_rs1_sid_i,
    input  logic [SID_W-1:0] disp_rs2_sid_i,
    input  logic [63:0]      disp_rs1_value_i,
    input  logic [63:0]      disp_rs2_value_i,
    input  logic             wb_valid_i,
    input  logic [SID_W-1:0] wb_sid_i,
    input  logic [63:0]      wb_value_i,
    output logic             branch_valid_o,
    output logic [63:0]      branch_pc_o,
    output logic [31:0]      branch_inst_o,
    output logic [SID_W-1:0] branch_sid_o,
    output logic [63:0]      rs1_value_o,
    output logic [63:0]      rs2_value_o,
    output logic [3:0]       func_code_o
);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] w_valid;
    biq_entry_t       w_ent [DEPTH];
    biq_entry_t       w_new, w_head;
    logic             w_disp, w_issue, w_rdy1, w_rdy2;

    assign disp_ready_o = (r_count != CNT_FULL);
    assign w_disp       = disp_valid_i & disp_ready_o & ~flush_i;

    // Operands a jump ignores are marked ready so they never gate issue.
    always_comb begin
        w_new.pc        = disp_pc_i;
        w_new.inst      = disp_inst_i;
        w_new.sid       = disp_sid_i;
        w_new.func      = disp_func_code_i;
        w_new.rs1_ready = disp_rs1_ready_i | (disp_func_code_i == FUNC_JAL);
        w_new.rs1_sid   = disp_rs1_sid_i;
        w_new.rs1_value = disp_rs1_value_i;
        w_new.rs2_ready = disp_rs2_ready_i | (disp_func_code_i == FUNC_JAL)
                        | (disp_func_code_i == FUNC_JALR);
        w_new.rs2_sid   = disp_rs2_sid_i;
        w_new.rs2_value = disp_rs2_value_i;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        branch_iq_entry u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_flush    (flush_i),
            .i_wr       (w_disp && (r_tail == PTR_W'(g))),
            .i_clr      (w_issue && (r_head == PTR_W'(g))),
            .i_data     (w_new),
            .i_wb_valid (wb_valid_i),
            .i_wb_sid   (wb_sid_i),
            .i_wb_value (wb_value_i),
            .o_valid    (w_valid[g]),
            .o_data     (w_ent[g])
        );
    end

    assign w_head = w_ent[r_head];

`ifdef BRANCH_IQ_FWD_EN
    logic w_fwd1, w_fwd2;
    assign w_fwd1      = wb_valid_i & ~w_head.rs1_ready & (w_head.rs1_sid == wb_sid_i);
    assign w_fwd2      = wb_valid_i & ~w_head.rs2_ready & (w_head.rs2_sid == wb_sid_i);
    assign w_rdy1      = w_head.rs1_ready | w_fwd1;
    assign w_rdy2      = w_head.rs2_ready | w_fwd2;
    assign rs1_value_o = w_fwd1 ? wb_value_i : w_head.rs1_value;
    assign rs2_value_o = w_fwd2 ? wb_value_i : w_head.rs2_value;
`else
    logic w_unused;
    assign w_unused    = ^{w_head.rs1_sid, w_head.rs2_sid, wb_value_i[0]} ^ (^{1'b0});
    assign w_rdy1      = w_head.rs1_ready;
    assign w_rdy2      = w_head.rs2_ready;
    assign rs1_value_o = w_head.rs1_value;
    assign rs2_value_o = w_head.rs2_value;
`endif

    assign w_issue        = w_valid[r_head] & w_rdy1 & w_rdy2 & ~flush_i;
    assign branch_valid_o = w_issue;
    assign branch_pc_o    = w_head.pc;
    assign branch_inst_o  = w_head.inst;
    assign branch_sid_o   = w_head.sid;
    assign func_code_o    = w_head.func;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_disp)
                r_tail <= r_tail + PTR_W'(1);
            if (w_issue)
                r_head <= r_head + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_disp) - (PTR_W+1)'(w_issue);
        end
    end
endmodule

// File: tb/tb_branch_issue_queue.sv
// Randomized + directed bench for branch_issue_queue with a queue-based reference model.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 6
`endif

module tb_branch_issue_queue;
    localparam int SW    = `SCOREBOARD_SIZE_WIDTH;
    localparam int DEPTH = 4;
    localparam logic [3:0] F_JAL = 4'b0111, F_JALR = 4'b0101, F_BR = 4'b0100;

    typedef struct {
        logic [63:0]   pc;
        logic [31:0]   inst;
        logic [SW-1:0] sid;
        logic [3:0]    func;
        bit            r1, r2;
        logic [SW-1:0] s1, s2;
        logic [63:0]   v1, v2;
    } ment_t;

    logic clk = 0, rst_n = 0, flush_i = 0, disp_valid_i = 0;
    logic disp_ready_o;
    logic [63:0] disp_pc_i = 0;
    logic [31:0] disp_inst_i = 0;
    logic [SW-1:0] disp_sid_i = 0, disp_rs1_sid_i = 0, disp_rs2_sid_i = 0, wb_sid_i = 0;
    logic [3:0] disp_func_code_i = 0;
    logic disp_rs1_ready_i = 0, disp_rs2_ready_i = 0, wb_valid_i = 0;
    logic [63:0] disp_rs1_value_i = 0, disp_rs2_value_i = 0, wb_value_i = 0;
    logic branch_valid_o;
    logic [63:0] branch_pc_o, rs1_value_o, rs2_value_o;
    logic [31:0] branch_inst_o;
    logic [SW-1:0] branch_sid_o;
    logic [3:0] func_code_o;

    branch_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_pc_i(disp_pc_i), .disp_inst_i(disp_inst_i), .disp_sid_i(disp_sid_i),
        .disp_func_code_i(disp_func_code_i),
        .disp_rs1_ready_i(disp_rs1_ready_i), .disp_rs2_ready_i(disp_rs2_ready_i),
        .disp_rs1_sid_i(disp_rs1_sid_i), .disp_rs2_sid_i(disp_rs2_sid_i),
        .disp_rs1_value_i(disp_rs1_value_i), .disp_rs2_value_i(disp_rs2_value_i),
        .wb_valid_i(wb_valid_i), .wb_sid_i(wb_sid_i), .wb_value_i(wb_value_i),
        .branch_valid_o(branch_valid_o), .branch_pc_o(branch_pc_o),
        .branch_inst_o(branch_inst_o), .branch_sid_o(branch_sid_o),
        .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o), .func_code_o(func_code_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    ment_t mq[$];  // model queue contents
    ment_t eq[$];  // expected issues, consumed by the monitor

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    function automatic ment_t mk(input logic [63:0] pc, input logic [3:0] f,
                                 input bit r1, input int s1, input logic [63:0] v1,
                                 input bit r2, input int s2, input logic [63:0] v2);
        ment_t m;
        m.pc = pc; m.inst = pc[31:0] ^ 32'hA5A5_0063; m.sid = SW'(pc[7:2]); m.func = f;
        m.r1 = r1; m.s1 = SW'(s1); m.v1 = v1; m.r2 = r2; m.s2 = SW'(s2); m.v2 = v2;
        return m;
    endfunction

    // One cycle: drive inputs at the falling edge, then advance the reference model.
    task automatic step(input bit fl, input bit dv, input ment_t d,
                        input bit wv, input int ws, input logic [63:0] wval);
        bit room;
        ment_t h, n;
        @(negedge clk);
        flush_i = fl; disp_valid_i = dv;
        disp_pc_i = d.pc; disp_inst_i = d.inst; disp_sid_i = d.sid; disp_func_code_i = d.func;
        disp_rs1_ready_i = d.r1; disp_rs1_sid_i = d.s1; disp_rs1_value_i = d.v1;
        disp_rs2_ready_i = d.r2; disp_rs2_sid_i = d.s2; disp_rs2_value_i = d.v2;
        wb_valid_i = wv; wb_sid_i = SW'(ws); wb_value_i = wval;
        #1;
        room = mq.size() < DEPTH;
        chk("disp_ready", 64'(disp_ready_o), 64'(room));
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) begin
                h = mq[0];
`ifdef BRANCH_IQ_FWD_EN
                if (!h.r1 && wv && h.s1 == SW'(ws)) begin h.r1 = 1; h.v1 = wval; end
                if (!h.r2 && wv && h.s2 == SW'(ws)) begin h.r2 = 1; h.v2 = wval; end
`endif
                if (h.r1 && h.r2) begin
                    eq.push_back(h);
                    void'(mq.pop_front());
                end
            end
            if (dv && room) begin
                n = d;
                if (n.func == F_JAL) begin n.r1 = 1; n.r2 = 1; end
                if (n.func == F_JALR) n.r2 = 1;
                mq.push_back(n);
            end
            if (wv)
                foreach (mq[i]) begin
                    if (!mq[i].r1 && mq[i].s1 == SW'(ws)) begin mq[i].r1 = 1; mq[i].v1 = wval; end
                    if (!mq[i].r2 && mq[i].s2 == SW'(ws)) begin mq[i].r2 = 1; mq[i].v2 = wval; end
                end
        end
    endtask

    task automatic idle(input int n);
        ment_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step(0, 0, z, 0, 0, 0);
    endtask

    // Monitor: every DUT issue must match the oldest expected issue.
    initial begin
        ment_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && branch_valid_o) begin
                if (eq.size() == 0) begin
                    chk("unexpected_issue", 64'(branch_valid_o), 64'd0);
                end else begin
                    e = eq.pop_front();
                    chk("issue_pc", branch_pc_o, e.pc);
                    chk("issue_inst", 64'(branch_inst_o), 64'(e.inst));
                    chk("issue_sid", 64'(branch_sid_o), 64'(e.sid));
                    chk("issue_func", 64'(func_code_o), 64'(e.func));
                    if (e.func != F_JAL) chk("issue_rs1", rs1_value_o, e.v1);
                    if (e.func == F_BR)  chk("issue_rs2", rs2_value_o, e.v2);
                end
            end
        end
    end

    initial begin
        ment_t z, d;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_branch_valid", 64'(branch_valid_o), 64'd0);
        chk("rst_disp_ready", 64'(disp_ready_o), 64'd1);
        chk("rst_pc", branch_pc_o, 64'd0);
        chk("rst_rs1", rs1_value_o, 64'd0);
        rst_n = 1;

        // Ready BEQ issues the cycle after dispatch.
        step(0, 1, mk(64'h1000, F_BR, 1, 0, 64'h11, 1, 0, 64'h22), 0, 0, 0);
        idle(2);
        // BNE waiting on sid 3, writeback two cycles later.
        step(0, 1, mk(64'h1004, F_BR, 0, 3, 0, 1, 0, 64'h7), 0, 0, 0);
        idle(1);
        step(0, 0, z, 1, 3, 64'h55);
        idle(2);
        // Stalled head blocks a younger ready JAL.
        step(0, 1, mk(64'h2000, F_BR, 0, 5, 0, 1, 0, 64'h9), 0, 0, 0);
        step(0, 1, mk(64'h2004, F_JAL, 0, 1, 0, 0, 2, 0), 0, 0, 0);
        idle(3);
        step(0, 0, z, 1, 5, 64'hABC);
        idle(3);
        // Fill, overflow attempt, unblock head, dispatch+issue at count 3.
        for (int i = 0; i < 4; i++)
            step(0, 1, mk(64'h3000 + 64'(4*i), F_BR, 0, 9 + i, 0, 1, 0, 64'(i)), 0, 0, 0);
        step(0, 1, mk(64'h3FF0, F_JAL, 1, 0, 0, 1, 0, 0), 0, 0, 0);
        step(0, 0, z, 1, 9, 64'h99);
        step(0, 0, z, 1, 10, 64'h1010);
        step(0, 1, mk(64'h3100, F_JALR, 1, 0, 64'h31, 0, 0, 0), 0, 0, 0);
        step(0, 1, mk(64'h3104, F_BR, 1, 0, 64'h41, 1, 0, 64'h42), 1, 11, 64'hB0B);
        step(0, 0, z, 1, 12, 64'hC0C);
        idle(6);
        // Flush with entries valid and a ready head; dispatch in the flush cycle dropped.
        for (int i = 0; i < 3; i++)
            step(0, 1, mk(64'h4000 + 64'(4*i), F_BR, 1, 0, 64'h1, 0, 20, 0), 0, 0, 0);
        step(0, 0, z, 1, 20, 64'h2020);
        step(1, 1, mk(64'h4100, F_BR, 1, 0, 1, 1, 0, 2), 0, 0, 0);
        idle(2);
        // Writeback of sid 7 captured in the dispatch cycle.
        step(0, 1, mk(64'h5000, F_BR, 1, 0, 64'h5, 0, 7, 0), 1, 7, 64'h777);
        idle(2);

        // Random phase.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] f;
            case ($urandom_range(0, 3))
                0: f = F_JAL;
                1: f = F_JALR;
                default: f = F_BR;
            endcase
            d = mk({$urandom, $urandom} & 64'hFFFF_FFFC, f,
                   bit'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom},
                   bit'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom});
            d.inst = $urandom; d.sid = SW'($urandom);
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60, d,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 7), {$urandom, $urandom});
            if (c == 300) begin
                // Asynchronous reset mid-operation drops everything.
                @(negedge clk);
                disp_valid_i = 0; wb_valid_i = 0; flush_i = 0;
                #3;
                rst_n = 0;
                #1;
                chk("midrst_branch_valid", 64'(branch_valid_o), 64'd0);
                chk("midrst_disp_ready", 64'(disp_ready_o), 64'd1);
                mq.delete();
                eq.delete();
                @(negedge clk);
                rst_n = 1;
            end
        end
        for (int s = 0; s < 8; s++) step(0, 0, z, 1, s, 64'(s) * 64'h1111);
        idle(6);
        @(negedge clk);
        #3;
        chk("pending_expected_issues", 64'(eq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
